// File: rtl/slave_out_fifo.sv
// Slave-side output FIFO: buffers result words and presents them on a valid/ready
// handshake, with optional even-parity screening and drop/overflow accounting.
module slave_out_fifo #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter bit          PARITY_EN = 1'b1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                       sig_clock,
   input  logic                       sig_reset_n,
   input  logic                       sig_in_valid,
   input  logic [DATA_W-1:0]          sig_in_data,
   input  logic                       sig_in_par,
   input  logic                       sig_clr,
   output logic                       sig_out_valid,
   output logic [DATA_W-1:0]          sig_out_data,
   input  logic                       sig_out_ready,
   output logic                       sig_overflow,
   output logic                       sig_err,
   output logic                       sig_almost_full,
   output logic [$clog2(DEPTH+1)-1:0] sig_level,
   output logic [CNT_W-1:0]           sig_drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [PW-1:0]     rd_ptr_nxt, wr_ptr_nxt;
   logic [LW-1:0]     level_nxt;
   logic [DATA_W-1:0] head_nxt;
   logic              full_c, pop_c, par_bad_c, good_c, push_c, ovf_c, drop_c;

   // Push/pop/drop decisions and next pointer state
   always_comb begin
      full_c     = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
      pop_c      = sig_out_valid && sig_out_ready;
      par_bad_c  = PARITY_EN && sig_in_valid && (^{sig_in_data, sig_in_par});
      good_c     = sig_in_valid && !par_bad_c;
      push_c     = good_c && (!full_c || pop_c);
      ovf_c      = good_c && full_c && !pop_c;
      drop_c     = par_bad_c || ovf_c;
      wr_ptr_nxt = push_c ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr_nxt = pop_c  ? rd_ptr + PW'(1) : rd_ptr;
      level_nxt  = LW'(wr_ptr_nxt - rd_ptr_nxt);
      // The incoming word becomes the head directly when it lands in the slot the head moves to
      if (push_c && (wr_ptr == rd_ptr_nxt)) begin
         head_nxt = sig_in_data;
      end else begin
         head_nxt = mem[rd_ptr_nxt[AW-1:0]];
      end
   end

   // Storage array, no reset needed: contents are qualified by the pointers
   always_ff @(posedge sig_clock) begin
      if (push_c && !sig_clr) begin
         mem[wr_ptr[AW-1:0]] <= sig_in_data;
      end
   end

   // Pointers, registered head and status
   always_ff @(posedge sig_clock or negedge sig_reset_n) begin
      if (!sig_reset_n) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         sig_level       <= '0;
         sig_out_valid   <= 1'b0;
         sig_out_data    <= '0;
         sig_almost_full <= 1'b0;
         sig_overflow    <= 1'b0;
         sig_err         <= 1'b0;
         sig_drop_cnt    <= '0;
      end else if (sig_clr) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         sig_level       <= '0;
         sig_out_valid   <= 1'b0;
         sig_out_data    <= '0;
         sig_almost_full <= 1'b0;
         sig_overflow    <= 1'b0;
         sig_err         <= 1'b0;
         sig_drop_cnt    <= '0;
      end else begin
         rd_ptr          <= rd_ptr_nxt;
         wr_ptr          <= wr_ptr_nxt;
         sig_level       <= level_nxt;
         sig_out_valid   <= (level_nxt != '0);
         sig_out_data    <= head_nxt;
         sig_almost_full <= (level_nxt >= LW'(AF_THRESH));
         sig_overflow    <= sig_overflow | ovf_c;
         sig_err         <= par_bad_c;
         if (drop_c && (sig_drop_cnt != '1)) begin
            sig_drop_cnt <= sig_drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_slave_out_fifo.sv
// Self-checking bench for slave_out_fifo: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_slave_out_fifo;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned AF    = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_par, clr, ready;
   logic [15:0] in_data;

   logic        a_valid, a_ovf, a_err, a_af;
   logic [15:0] a_data;
   logic [3:0]  a_level;
   logic [7:0]  a_cnt;
   logic        b_valid, b_ovf, b_err, b_af;
   logic [15:0] b_data;
   logic [3:0]  b_level;
   logic [1:0]  b_cnt;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   slave_out_fifo #(.DATA_W(16), .DEPTH(8), .AF_THRESH(6), .PARITY_EN(1'b1), .CNT_W(8)) dut_a (
      .sig_clock(clk), .sig_reset_n(rst_n), .sig_in_valid(in_valid), .sig_in_data(in_data),
      .sig_in_par(in_par), .sig_clr(clr), .sig_out_valid(a_valid), .sig_out_data(a_data),
      .sig_out_ready(ready), .sig_overflow(a_ovf), .sig_err(a_err), .sig_almost_full(a_af),
      .sig_level(a_level), .sig_drop_cnt(a_cnt));

   slave_out_fifo #(.DATA_W(16), .DEPTH(8), .AF_THRESH(6), .PARITY_EN(1'b0), .CNT_W(2)) dut_b (
      .sig_clock(clk), .sig_reset_n(rst_n), .sig_in_valid(in_valid), .sig_in_data(in_data),
      .sig_in_par(in_par), .sig_clr(clr), .sig_out_valid(b_valid), .sig_out_data(b_data),
      .sig_out_ready(ready), .sig_overflow(b_ovf), .sig_err(b_err), .sig_almost_full(b_af),
      .sig_level(b_level), .sig_drop_cnt(b_cnt));

   // Reference model for dut_a
   logic [15:0] mq[$];
   logic        m_ovf, m_err;
   int          m_cnt;

   function automatic logic gp(input logic [15:0] d);
      return ^d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_step();
      bit full, pop, bad, good;
      if (clr) begin
         model_reset();
      end else begin
         full = (mq.size() == DEPTH);
         pop  = (mq.size() != 0) && ready;
         bad  = in_valid && (^{in_data, in_par});
         good = in_valid && !bad;
         m_err = bad;
         if (pop) void'(mq.pop_front());
         if (good) begin
            if (full && !pop) begin
               m_ovf = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end else begin
               mq.push_back(in_data);
            end
         end
         if (bad && m_cnt < 255) m_cnt++;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_model();
      chk("valid", 32'(a_valid), 32'(mq.size() != 0));
      chk("level", 32'(a_level), 32'(mq.size()));
      chk("almost_full", 32'(a_af), 32'(mq.size() >= AF));
      chk("overflow", 32'(a_ovf), 32'(m_ovf));
      chk("err", 32'(a_err), 32'(m_err));
      chk("drop_cnt", 32'(a_cnt), 32'(m_cnt));
      if (mq.size() != 0) chk("data", 32'(a_data), 32'(mq[0]));
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic p, input logic r, input logic c);
      in_valid = v;
      in_data  = d;
      in_par   = p;
      ready    = r;
      clr      = c;
   endtask

   typedef struct {
      logic v; logic [15:0] d; logic p; logic r; logic c;
      logic ev; logic [15:0] ed; logic [3:0] el; logic ee; logic [7:0] ec;
   } vec_t;

   vec_t        tv[8];
   logic [15:0] exp_drain[8];
   logic [15:0] rx[$];
   logic [15:0] held;

   initial begin
      tv[0] = '{1'b1, 16'h1234, gp(16'h1234), 1'b0, 1'b0, 1'b1, 16'h1234, 4'd1, 1'b0, 8'd0};
      tv[1] = '{1'b0, 16'h0000, 1'b0,         1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 8'd0};
      tv[2] = '{1'b1, 16'h0001, 1'b0,         1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 8'd1};
      tv[3] = '{1'b0, 16'h0000, 1'b0,         1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 8'd1};
      tv[4] = '{1'b1, 16'hBEEF, gp(16'hBEEF), 1'b0, 1'b0, 1'b1, 16'hBEEF, 4'd1, 1'b0, 8'd1};
      tv[5] = '{1'b1, 16'h00FF, gp(16'h00FF), 1'b1, 1'b0, 1'b1, 16'h00FF, 4'd1, 1'b0, 8'd1};
      tv[6] = '{1'b0, 16'h0000, 1'b0,         1'b0, 1'b0, 1'b1, 16'h00FF, 4'd1, 1'b0, 8'd1};
      tv[7] = '{1'b1, 16'h5555, gp(16'h5555), 1'b1, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 8'd0};

      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_data", 32'(a_data), 32'd0);
      chk("rst_level", 32'(a_level), 32'd0);
      chk("rst_flags", 32'({a_ovf, a_err, a_af}), 32'd0);
      chk("rst_cnt", 32'(a_cnt), 32'd0);
      chk("rst_b", 32'({b_valid, b_ovf, b_err, b_af, b_level, b_cnt}), 32'd0);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 8; i++) begin
         drive(tv[i].v, tv[i].d, tv[i].p, tv[i].r, tv[i].c);
         tick();
         chk($sformatf("tv%0d_valid", i), 32'(a_valid), 32'(tv[i].ev));
         if (tv[i].ev) chk($sformatf("tv%0d_data", i), 32'(a_data), 32'(tv[i].ed));
         chk($sformatf("tv%0d_level", i), 32'(a_level), 32'(tv[i].el));
         chk($sformatf("tv%0d_err", i), 32'(a_err), 32'(tv[i].ee));
         chk($sformatf("tv%0d_cnt", i), 32'(a_cnt), 32'(tv[i].ec));
      end

      // Fill to full, overflow, saturating counter on the CNT_W=2 instance
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'(i), gp(16'(i)), 1'b0, 1'b0);
         tick();
         chk("fill_level", 32'(a_level), 32'(i + 1));
         chk("fill_af", 32'(a_af), 32'((i + 1) >= 6));
      end
      for (int j = 0; j < 5; j++) begin
         drive(1'b1, 16'(16'h100 + j), gp(16'(16'h100 + j)), 1'b0, 1'b0);
         tick();
         if (j == 0) begin
            chk("ovf_first", 32'(a_ovf), 32'd1);
            chk("ovf_cnt1", 32'(a_cnt), 32'd1);
         end
      end
      chk("ovf_cnt5", 32'(a_cnt), 32'd5);
      chk("sat_cnt_b", 32'(b_cnt), 32'd3);
      chk("ovf_b", 32'(b_ovf), 32'd1);
      drive(1'b1, 16'hAAAA, gp(16'hAAAA), 1'b1, 1'b0);
      tick();
      chk("full_pp_level", 32'(a_level), 32'd8);
      chk("full_pp_cnt", 32'(a_cnt), 32'd5);
      check_model();
      exp_drain = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'hAAAA};
      drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         chk("drain_data", 32'(a_data), 32'(exp_drain[k]));
         tick();
      end
      chk("drain_empty", 32'(a_valid), 32'd0);

      // Parity failure on checking instance, accepted when checking disabled
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
      drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0); tick();
      chk("par_err", 32'(a_err), 32'd1);
      chk("par_level", 32'(a_level), 32'd0);
      chk("par_cnt", 32'(a_cnt), 32'd1);
      chk("par_ovf", 32'(a_ovf), 32'd0);
      chk("nopar_level", 32'(b_level), 32'd1);
      chk("nopar_data", 32'(b_data), 32'h0001);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0); tick();
      chk("par_err_pulse", 32'(a_err), 32'd0);
      check_model();

      // Head stability under backpressure
      drive(1'b1, 16'h4321, gp(16'h4321), 1'b0, 1'b0); tick();
      held = a_data;
      chk("hold_first", 32'(held), 32'h4321);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 16'(16'h700 + k), gp(16'(16'h700 + k)), 1'b0, 1'b0);
         tick();
         chk("hold_data", 32'(a_data), 32'h4321);
      end

      // Async reset mid-cycle with level 5
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 16'(16'h900 + k), gp(16'(16'h900 + k)), 1'b0, 1'b0);
         tick();
      end
      chk("pre_rst_level", 32'(a_level), 32'd5);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(a_valid), 32'd0);
      chk("arst_level", 32'(a_level), 32'd0);
      chk("arst_data", 32'(a_data), 32'd0);
      chk("arst_cnt_flags", 32'({a_cnt, a_ovf, a_af, a_err}), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Wrap-around: 20 words through 8 entries with alternating ready
      rx.delete();
      for (int c = 0; c < 60; c++) begin
         drive(c < 40 && (c % 2 == 0), 16'(16'hC00 + c / 2), gp(16'(16'hC00 + c / 2)), c % 2 == 1 || c >= 40, 1'b0);
         if (a_valid && ready) rx.push_back(a_data);
         tick();
         check_model();
      end
      chk("wrap_count", 32'(rx.size()), 32'd20);
      for (int k = 0; k < rx.size() && k < 20; k++) chk("wrap_order", 32'(rx[k]), 32'(16'hC00 + k));

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 16'($urandom);
         in_par   = gp(in_data) ^ ($urandom_range(0, 15) == 0);
         ready    = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr      = ($urandom_range(0, 199) == 0);
         tick();
         check_model();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
